// File: rtl/axi4lite_gpi_regs.sv
// AXI4-Lite register block with four RW registers, a synchronized GPI input register
// and a sticky rising-edge capture register. reg0 drives gpo_out.
module axi4lite_gpi_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned C_GPI_WIDTH        = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [C_GPI_WIDTH-1:0]            gpi_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     gpo_out
);
    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned GW     = C_GPI_WIDTH;
    localparam int unsigned NUM_RW = 4;
    localparam int unsigned IDX_W  = 3;
    localparam logic [IDX_W-1:0] IDX_GPI_IN   = 3'd4;
    localparam logic [IDX_W-1:0] IDX_GPI_EDGE = 3'd5;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_held, w_held;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] regs [NUM_RW];
    logic [GW-1:0] gpi_meta, gpi_sync, gpi_prev, edge_q;

    logic          aw_hs, w_hs, ar_hs, r_hs, commit;
    logic [AW-1:0] cm_addr;
    logic [DW-1:0] cm_data, cm_mask;
    logic [SW-1:0] cm_strb;
    logic [IDX_W-1:0] cm_idx, ar_idx;
    logic [GW-1:0] edge_set, edge_clr, edge_next;
    logic [DW-1:0] rd_val;
    logic [1:0]    rd_resp;
    logic          unused_ok;

    // Write path: held entries bypass to the commit so a fresh handshake commits at once.
    always_comb begin
        aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
        w_hs    = S_AXI_WVALID & S_AXI_WREADY;
        cm_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
        cm_data = w_held ? w_data_q : S_AXI_WDATA;
        cm_strb = w_held ? w_strb_q : S_AXI_WSTRB;
        commit  = (aw_held | aw_hs) & (w_held | w_hs) & ~S_AXI_BVALID;
        cm_idx  = cm_addr[2 +: IDX_W];
        cm_mask = '0;
        for (int i = 0; i < int'(SW); i++) begin
            cm_mask[8*i +: 8] = {8{cm_strb[i]}};
        end
        edge_set = gpi_sync & ~gpi_prev;
        edge_clr = '0;
        if (commit && cm_idx == IDX_GPI_EDGE) begin
            edge_clr = cm_data[GW-1:0] & cm_mask[GW-1:0];
        end
        edge_next = (edge_q & ~edge_clr) | edge_set;
    end

    // Read decode from current register state (pre-write on a same-cycle commit).
    always_comb begin
        ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
        r_hs    = S_AXI_RVALID & S_AXI_RREADY;
        ar_idx  = S_AXI_ARADDR[2 +: IDX_W];
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (ar_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_val = regs[ar_idx[1:0]];
            IDX_GPI_IN:             rd_val = DW'(gpi_sync);
            IDX_GPI_EDGE:           rd_val = DW'(edge_q);
            default:                rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin : write_channel
        if (ARESET) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            for (int i = 0; i < int'(NUM_RW); i++) regs[i] <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
            S_AXI_AWREADY <= ~((aw_held | aw_hs) & ~commit);
            S_AXI_WREADY  <= ~((w_held | w_hs) & ~commit);
            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= (cm_idx[2:1] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
                if (!cm_idx[2]) begin
                    regs[cm_idx[1:0]] <= (regs[cm_idx[1:0]] & ~cm_mask) | (cm_data & cm_mask);
                end
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin : read_channel
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_val;
            S_AXI_RRESP   <= rd_resp;
        end else if (r_hs) begin
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
        end else begin
            S_AXI_ARREADY <= ~S_AXI_RVALID;
        end
    end

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge ACLK or posedge ARESET) begin : gpi_path
        if (ARESET) begin
            gpi_meta <= '0;
            gpi_sync <= '0;
            gpi_prev <= '0;
            edge_q   <= '0;
        end else begin
            gpi_meta <= gpi_in;
            gpi_sync <= gpi_meta;
            gpi_prev <= gpi_sync;
            edge_q   <= edge_next;
        end
    end

    assign gpo_out   = regs[0];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, cm_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4lite_gpi_regs.sv
// Self-checking bench for axi4lite_gpi_regs: directed scenarios plus randomized
// traffic checked against a register-map reference model.
module tb_axi4lite_gpi_regs;
    localparam int unsigned AW = 5;
    localparam int unsigned GW = 8;
    localparam int TIMEOUT = 64;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          ACLK;
    logic          ARESET;
    logic [AW-1:0] S_AXI_AWADDR;
    logic [2:0]    S_AXI_AWPROT;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [AW-1:0] S_AXI_ARADDR;
    logic [2:0]    S_AXI_ARPROT;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [GW-1:0] gpi_in;
    logic [31:0]   gpo_out;

    int tests_run;
    int tests_failed;
    logic [31:0]   model_regs [4];
    logic [GW-1:0] model_gpi;
    logic [GW-1:0] model_edge;

    axi4lite_gpi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_GPI_WIDTH(GW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .gpi_in(gpi_in), .gpo_out(gpo_out)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reference model: register map semantics at the transaction level.
    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp);
        resp = (idx >= 6) ? SLVERR : OKAY;
        if (idx < 4) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
        end else if (idx == 5) begin
            for (int i = 0; i < int'(GW); i++)
                if (data[i] && strb[i/8]) model_edge[i] = 1'b0;
        end
    endtask

    task automatic model_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
        resp = OKAY;
        data = '0;
        if (idx < 4) data = model_regs[idx];
        else if (idx == 4) data = 32'(model_gpi);
        else if (idx == 5) data = 32'(model_edge);
        else resp = SLVERR;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_regs[i] = '0;
        model_edge = '0;
    endtask

    task automatic bus_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int cyc;
        bit done, aw_hs, w_hs, b_hs;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        done = 1'b0; cyc = 0; resp = 'x;
        while (!done && cyc < TIMEOUT) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            b_hs  = S_AXI_BVALID && S_AXI_BREADY;
            if (b_hs) resp = S_AXI_BRESP;
            tick();
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs) S_AXI_WVALID = 1'b0;
            if (b_hs) done = 1'b1;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL write_timeout addr=%h: no B response, required within %0d cycles", addr, TIMEOUT);
        end
    endtask

    task automatic bus_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit done, ar_hs, r_hs;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        done = 1'b0; cyc = 0; data = 'x; resp = 'x;
        while (!done && cyc < TIMEOUT) begin
            ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
            r_hs  = S_AXI_RVALID && S_AXI_RREADY;
            if (r_hs) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
            tick();
            if (ar_hs) S_AXI_ARVALID = 1'b0;
            if (r_hs) done = 1'b1;
            cyc++;
        end
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL read_timeout addr=%h: no R response, required within %0d cycles", addr, TIMEOUT);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, ed;
        logic [1:0] r, er;
        ARESET = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshakes: got %b, expected 00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        tests_run++;
        if ({S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP, gpo_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b gpo=%h, expected all 0",
                     S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP, gpo_out);
        end
        ARESET = 1'b0;
        model_reset();
        tick(); tick();
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b, expected 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(5'(4*i), d, r);
            model_read(i, ed, er);
            tests_run++;
            if ({d, r} !== {ed, er}) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: got %h/%b, expected %h/%b", i, d, r, ed, er);
            end
        end
    endtask

    task automatic test_rw_regs();
        logic [31:0] d, ed;
        logic [1:0] r, er;
        for (int i = 0; i < 4; i++) begin
            bus_write(5'(4*i), 32'(i+1), 4'hF, r);
            model_write(i, 32'(i+1), 4'hF, er);
            tests_run++;
            if (r !== er) begin
                tests_failed++;
                $display("FAIL rw_bresp%0d: got %b, expected %b", i, r, er);
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(5'(4*i), d, r);
            model_read(i, ed, er);
            tests_run++;
            if ({d, r} !== {ed, er}) begin
                tests_failed++;
                $display("FAIL rw_readback%0d: got %h/%b, expected %h/%b", i, d, r, ed, er);
            end
        end
        tests_run++;
        if (gpo_out !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL rw_gpo: got %h, expected 00000001", gpo_out);
        end
    endtask

    task automatic test_w_leads_aw();
        logic [31:0] d, ed;
        logic [1:0] r, er;
        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'h3; S_AXI_WVALID = 1'b1;
        tests_run++;
        if (S_AXI_WREADY !== 1'b1) begin
            tests_failed++;
            $display("FAIL wlead_wready: got %b, expected 1", S_AXI_WREADY);
        end
        tick();
        S_AXI_WVALID = 1'b0;
        tick(); tick();
        tests_run++;
        if ({S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY} !== 3'b001) begin
            tests_failed++;
            $display("FAIL wlead_held: wready/bvalid/awready got %b, expected 001",
                     {S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY});
        end
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        model_write(2, 32'hDEAD_BEEF, 4'h3, er);
        tests_run++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, er}) begin
            tests_failed++;
            $display("FAIL wlead_bvalid_latency: bvalid/bresp got %b/%b, expected 1/%b",
                     S_AXI_BVALID, S_AXI_BRESP, er);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        tests_run++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
            tests_failed++;
            $display("FAIL wlead_b_done: bvalid/awready/wready got %b, expected 011",
                     {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
        end
        bus_read(5'h08, d, r);
        model_read(2, ed, er);
        tests_run++;
        if ({d, r} !== {ed, er}) begin
            tests_failed++;
            $display("FAIL wlead_readback: got %h/%b, expected %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, d, ed;
        logic [1:0] r, er, er1, er2;
        d1 = $urandom(); d2 = $urandom();
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        model_write(1, d1, 4'hF, er1);
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = d2;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        bus_read(5'h0C, d, r);
        model_read(3, ed, er);
        tests_run++;
        if ({d, r} !== {ed, er}) begin
            tests_failed++;
            $display("FAIL b2b_not_committed: reg3 got %h/%b, expected %h/%b", d, r, ed, er);
        end
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== {1'b1, er1, 2'b00}) begin
                tests_failed++;
                $display("FAIL b2b_stall%0d: bvalid/bresp/awready/wready got %b, expected %b",
                         k, {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, {1'b1, er1, 2'b00});
            end
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        tests_run++;
        if (S_AXI_BVALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: bvalid got %b, expected 0", S_AXI_BVALID);
        end
        tick();
        model_write(3, d2, 4'hF, er2);
        tests_run++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, er2}) begin
            tests_failed++;
            $display("FAIL b2b_second_b: bvalid/bresp got %b/%b, expected 1/%b", S_AXI_BVALID, S_AXI_BRESP, er2);
        end
        tick();
        S_AXI_BREADY = 1'b0;
        for (int i = 1; i < 4; i += 2) begin
            bus_read(5'(4*i), d, r);
            model_read(i, ed, er);
            tests_run++;
            if ({d, r} !== {ed, er}) begin
                tests_failed++;
                $display("FAIL b2b_readback%0d: got %h/%b, expected %h/%b", i, d, r, ed, er);
            end
        end
    endtask

    task automatic test_gpi_edge();
        logic [31:0] d, ed;
        logic [1:0] r, er;
        gpi_in = '0;
        repeat (4) tick();
        gpi_in[0] = 1'b1;
        tick();
        bus_read(5'h10, d, r);
        tests_run++;
        if ({d, r} !== {32'h0, OKAY}) begin
            tests_failed++;
            $display("FAIL gpi_too_early: got %h/%b, expected 00000000/00", d, r);
        end
        model_gpi = 8'h01;
        model_edge = 8'h01;
        for (int i = 4; i < 6; i++) begin
            bus_read(5'(4*i), d, r);
            model_read(i, ed, er);
            tests_run++;
            if ({d, r} !== {ed, er}) begin
                tests_failed++;
                $display("FAIL gpi_read%0d: got %h/%b, expected %h/%b", i, d, r, ed, er);
            end
        end
        bus_write(5'h14, 32'h1, 4'hF, r);
        model_write(5, 32'h1, 4'hF, er);
        bus_read(5'h14, d, r);
        model_read(5, ed, er);
        tests_run++;
        if ({d, r} !== {ed, er}) begin
            tests_failed++;
            $display("FAIL gpi_w1c: got %h/%b, expected %h/%b", d, r, ed, er);
        end
        gpi_in[0] = 1'b0;
        repeat (4) tick();
        gpi_in[0] = 1'b1;
        tick(); tick();
        S_AXI_AWADDR = 5'h14; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tests_run++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, OKAY}) begin
            tests_failed++;
            $display("FAIL gpi_race_b: bvalid/bresp got %b/%b, expected 1/00", S_AXI_BVALID, S_AXI_BRESP);
        end
        tick();
        S_AXI_BREADY = 1'b0;
        bus_read(5'h14, d, r);
        tests_run++;
        if ({d, r} !== {32'h1, OKAY}) begin
            tests_failed++;
            $display("FAIL gpi_set_dominates: got %h/%b, expected 00000001/00", d, r);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d, ed;
        logic [1:0] r, er;
        bus_read(5'h18, d, r);
        tests_run++;
        if ({d, r} !== {32'h0, SLVERR}) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h/%b, expected 00000000/10", d, r);
        end
        bus_write(5'h1C, $urandom(), 4'hF, r);
        model_write(7, 32'h0, 4'hF, er);
        tests_run++;
        if (r !== er) begin
            tests_failed++;
            $display("FAIL unmapped_write: bresp got %b, expected %b", r, er);
        end
        bus_write(5'h10, 32'hFFFF_FFFF, 4'hF, r);
        tests_run++;
        if (r !== OKAY) begin
            tests_failed++;
            $display("FAIL gpi_in_write: bresp got %b, expected 00", r);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(5'(4*i), d, r);
            model_read(i, ed, er);
            tests_run++;
            if ({d, r} !== {ed, er}) begin
                tests_failed++;
                $display("FAIL unmapped_unchanged%0d: got %h/%b, expected %h/%b", i, d, r, ed, er);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ed, dn;
        logic [1:0] r, er;
        gpi_in = '0;
        model_gpi = '0;
        repeat (4) tick();
        bus_write(5'h00, 32'hA5A5_0001, 4'hF, r);
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        tests_run++;
        if ({S_AXI_RVALID, S_AXI_AWREADY, gpo_out} !== {2'b10, 32'hA5A5_0001}) begin
            tests_failed++;
            $display("FAIL midrst_setup: rvalid/awready/gpo got %b/%b/%h, expected 1/0/a5a50001",
                     S_AXI_RVALID, S_AXI_AWREADY, gpo_out);
        end
        #2 ARESET = 1'b1;
        #1;
        tests_run++;
        if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_RDATA, gpo_out} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_async: rvalid=%b bvalid=%b arready=%b awready=%b rdata=%h gpo=%h, expected all 0",
                     S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_RDATA, gpo_out);
        end
        tick();
        ARESET = 1'b0;
        model_reset();
        tick(); tick();
        dn = $urandom();
        bus_write(5'h08, dn, 4'hF, r);
        model_write(2, dn, 4'hF, er);
        tests_run++;
        if (r !== er) begin
            tests_failed++;
            $display("FAIL midrst_first_write: bresp got %b, expected %b", r, er);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(5'(4*i), d, r);
            model_read(i, ed, er);
            tests_run++;
            if ({d, r} !== {ed, er}) begin
                tests_failed++;
                $display("FAIL midrst_reg%0d: got %h/%b, expected %h/%b", i, d, r, ed, er);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ed, data;
        logic [1:0] r, er, lo;
        logic [3:0] strb;
        logic [GW-1:0] g;
        int op, idx;
        for (int n = 0; n < 80; n++) begin
            op  = int'($urandom_range(0, 2));
            idx = int'($urandom_range(0, 7));
            lo  = 2'($urandom_range(0, 3));
            if (op == 0) begin
                data = $urandom();
                strb = 4'($urandom_range(0, 15));
                bus_write(5'(idx*4 + int'(lo)), data, strb, r);
                model_write(idx, data, strb, er);
                tests_run++;
                if ({r, gpo_out} !== {er, model_regs[0]}) begin
                    tests_failed++;
                    $display("FAIL rand_write%0d idx=%0d: bresp/gpo got %b/%h, expected %b/%h",
                             n, idx, r, gpo_out, er, model_regs[0]);
                end
            end else if (op == 1) begin
                bus_read(5'(idx*4 + int'(lo)), d, r);
                model_read(idx, ed, er);
                tests_run++;
                if ({d, r} !== {ed, er}) begin
                    tests_failed++;
                    $display("FAIL rand_read%0d idx=%0d: got %h/%b, expected %h/%b", n, idx, d, r, ed, er);
                end
            end else begin
                g = GW'($urandom());
                gpi_in = g;
                repeat (4) tick();
                model_edge = model_edge | (g & ~model_gpi);
                model_gpi = g;
            end
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        model_gpi = '0; model_edge = '0;
        for (int i = 0; i < 4; i++) model_regs[i] = '0;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        gpi_in = '0;
        test_reset();
        test_rw_regs();
        test_w_leads_aw();
        test_back_to_back();
        test_gpi_edge();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

endmodule
